rq_pkt_arbiter: RTL
===================

Name: rq_pkt_arbiter

Overview:
Packet-atomic round-robin arbiter sharing one DMA requester-request (RQ) AXIS-like stream between two requesters: ch0 = read-request generator, ch1 = write-request generator. Sits in the dma_clk domain, directly upstream of the RQ async FIFO input (dma_axis_rq_*). A grant is held from the first beat of a packet through its tlast beat, so packets are never interleaved. A single-entry registered output stage breaks the timing path to the downstream FIFO.

Parameters:
DATA_W, 256, tdata width (equals `DMA_DATA_W`)
KEEP_W, 8, tkeep width (equals `DMA_KEEP_W`)
USER_W, 60, tuser width (RQ tuser layout)
CNT_W, 16, width of the per-channel packet counters

Ports:
dma_clk  in  1  block clock; the only clock
dma_rst_n  in  1  reset, asynchronous, active-low
ch0_axis_rq_tvalid  in  1  ch0 beat valid
ch0_axis_rq_tlast  in  1  ch0 last beat of packet
ch0_axis_rq_tdata  in  DATA_W  ch0 data
ch0_axis_rq_tuser  in  USER_W  ch0 tuser
ch0_axis_rq_tkeep  in  KEEP_W  ch0 keep
ch0_axis_rq_tready  out  1  ch0 beat accepted
ch1_axis_rq_*  same set and widths as ch0 (tvalid/tlast/tdata/tuser/tkeep in, tready out)
dma_axis_rq_tvalid  out  1  merged output valid
dma_axis_rq_tlast  out  1  merged output last
dma_axis_rq_tdata  out  DATA_W  merged output data
dma_axis_rq_tuser  out  USER_W  merged output tuser
dma_axis_rq_tkeep  out  KEEP_W  merged output keep
dma_axis_rq_tready  in  1  downstream ready
ch0_pkt_cnt  out  CNT_W  ch0 packets forwarded (debug)
ch1_pkt_cnt  out  CNT_W  ch1 packets forwarded (debug)

Behaviour:
- Clock/reset: single clock dma_clk; dma_rst_n asynchronous, active-low.
- Reset values: state=IDLE, last_gnt=1 (so ch0 wins the first contention), output valid=0, tlast/tdata/tuser/tkeep=0, both chN_tready=0, both counters=0.
- FSM states: IDLE, GNT0, GNT1.
- IDLE: no beat accepted. If exactly one chN_tvalid is high -> GNTN. If both are high -> grant the channel != last_gnt. If neither -> stay in IDLE. The grant is registered, so the first beat is accepted on the cycle after the decision (1-cycle bubble out of IDLE).
- Output register: out_free = !dma_axis_rq_tvalid | dma_axis_rq_tready.
- In GNTN: chN_tready = out_free; the other channel's tready = 0.
- Accept = chN_tvalid & chN_tready. On accept, the beat (tlast, tdata, tuser, tkeep) loads into the output register and dma_axis_rq_tvalid=1 next cycle. Latency from input to output is exactly 1 cycle.
- Output hold: the output register holds its contents stable while dma_axis_rq_tvalid=1 and dma_axis_rq_tready=0.
- Output clear: when the register empties with no new accept, tvalid goes to 0. Data fields are don't-care but are driven to 0.
- Accepted beat with tlast=1 in GNTN:
  - last_gnt <= N.
  - chN_pkt_cnt increments, wrapping modulo 2^CNT_W.
  - Next state: the other channel's tvalid is high -> GNT(other), with no bubble; else chN_tvalid is high -> GNTN; else -> IDLE.
- Accepted beat with tlast=0: stay in GNTN. The grant is never revoked mid-packet, even if chN deasserts tvalid (no accept that cycle, state held).
- Single-beat packets: full rate; a strict ch0/ch1 alternation sustains 1 beat/cycle with no bubbles while downstream is ready.
- Backpressure: dma_axis_rq_tready=0 for K cycles stalls the granted channel K cycles. No beat is lost or duplicated.
- tuser passes through unmodified; no width conversion.
- Reset mid-packet: the partial packet is dropped, the FSM returns to IDLE, and counters clear. Requesters are also reset by dma_rst_n.
- Counter update: counters are updated on the input-accept cycle, not on output drain.

Test Plan:
- Reset released, ch0 sends a 3-beat packet (tdata 0x1,0x2,0x3), downstream always ready -> output beats 0x1..0x3 at input-accept+1 cycles, tlast only on 0x3, ch0_pkt_cnt=1, ch1_tready=0 throughout.
- ch0 and ch1 both assert tvalid in the same cycle from IDLE, each with a 2-beat packet -> the ch0 packet is output first, then the ch1 packet with no idle cycle between, beats never interleaved; afterwards last_gnt=1 and both counters=1.
- Both channels stream 4 single-beat packets each continuously -> output order ch0,ch1,ch0,ch1,..., 8 beats in 8 consecutive cycles after the first grant bubble.
- Mid-packet backpressure: ch1 sends 4 beats, dma_axis_rq_tready=0 for 5 cycles after beat 2 is output -> beat 2 held stable for 5 cycles, ch1_tready=0 during the stall, all 4 beats delivered in order exactly once.
- Granted ch0 deasserts tvalid for 3 cycles mid-packet while ch1 is valid -> ch1_tready stays 0; ch0's packet completes before any ch1 beat is accepted.
- dma_rst_n asserted during beat 2 of a 4-beat ch0 packet -> dma_axis_rq_tvalid=0, counters=0, and state IDLE immediately (asynchronous); after release, a fresh ch1 packet is forwarded correctly.

Source files
------------

// File: rtl/rq_pkt_arbiter.sv
// Packet-atomic round-robin arbiter merging the read and write
// RQ request streams into one registered AXIS output.
module rq_pkt_arbiter #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = 8,
  parameter int USER_W = 60,
  parameter int CNT_W  = 16
) (
  input  logic              dma_clk,
  input  logic              dma_rst_n,
  input  logic              ch0_axis_rq_tvalid,
  input  logic              ch0_axis_rq_tlast,
  input  logic [DATA_W-1:0] ch0_axis_rq_tdata,
  input  logic [USER_W-1:0] ch0_axis_rq_tuser,
  input  logic [KEEP_W-1:0] ch0_axis_rq_tkeep,
  output logic              ch0_axis_rq_tready,
  input  logic              ch1_axis_rq_tvalid,
  input  logic              ch1_axis_rq_tlast,
  input  logic [DATA_W-1:0] ch1_axis_rq_tdata,
  input  logic [USER_W-1:0] ch1_axis_rq_tuser,
  input  logic [KEEP_W-1:0] ch1_axis_rq_tkeep,
  output logic              ch1_axis_rq_tready,
  output logic              dma_axis_rq_tvalid,
  output logic              dma_axis_rq_tlast,
  output logic [DATA_W-1:0] dma_axis_rq_tdata,
  output logic [USER_W-1:0] dma_axis_rq_tuser,
  output logic [KEEP_W-1:0] dma_axis_rq_tkeep,
  input  logic              dma_axis_rq_tready,
  output logic [CNT_W-1:0]  ch0_pkt_cnt,
  output logic [CNT_W-1:0]  ch1_pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t state_q, state_d;
  logic   last_gnt_q, last_gnt_d;

  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [USER_W-1:0] user_q, user_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic [CNT_W-1:0]  cnt0_q, cnt1_q;

  logic out_free;
  logic rdy0, rdy1;
  logic acc0, acc1;
  logic end0, end1;

  assign out_free = !vld_q | dma_axis_rq_tready;
  assign rdy0     = (state_q == GNT0) & out_free;
  assign rdy1     = (state_q == GNT1) & out_free;
  assign acc0     = ch0_axis_rq_tvalid & rdy0;
  assign acc1     = ch1_axis_rq_tvalid & rdy1;
  assign end0     = acc0 & ch0_axis_rq_tlast;
  assign end1     = acc1 & ch1_axis_rq_tlast;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      IDLE: begin
        if (ch0_axis_rq_tvalid & ch1_axis_rq_tvalid)
          state_d = last_gnt_q ? GNT0 : GNT1;
        else if (ch0_axis_rq_tvalid)
          state_d = GNT0;
        else if (ch1_axis_rq_tvalid)
          state_d = GNT1;
      end
      GNT0: begin
        if (end0) begin
          last_gnt_d = 1'b0;
          if (ch1_axis_rq_tvalid)
            state_d = GNT1;
          else if (ch0_axis_rq_tvalid)
            state_d = GNT0;
          else
            state_d = IDLE;
        end
      end
      GNT1: begin
        if (end1) begin
          last_gnt_d = 1'b1;
          if (ch0_axis_rq_tvalid)
            state_d = GNT0;
          else if (ch1_axis_rq_tvalid)
            state_d = GNT1;
          else
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-entry output stage; cleared to zero when drained
  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    data_d = data_q;
    user_d = user_q;
    keep_d = keep_q;
    if (acc0) begin
      vld_d  = 1'b1;
      last_d = ch0_axis_rq_tlast;
      data_d = ch0_axis_rq_tdata;
      user_d = ch0_axis_rq_tuser;
      keep_d = ch0_axis_rq_tkeep;
    end else if (acc1) begin
      vld_d  = 1'b1;
      last_d = ch1_axis_rq_tlast;
      data_d = ch1_axis_rq_tdata;
      user_d = ch1_axis_rq_tuser;
      keep_d = ch1_axis_rq_tkeep;
    end else if (dma_axis_rq_tready) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
      data_d = '0;
      user_d = '0;
      keep_d = '0;
    end
  end

  always_ff @(posedge dma_clk or negedge dma_rst_n) begin
    if (!dma_rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      user_q     <= '0;
      keep_q     <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      data_q     <= data_d;
      user_q     <= user_d;
      keep_q     <= keep_d;
      if (end0)
        cnt0_q <= cnt0_q + 1'b1;
      if (end1)
        cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign ch0_axis_rq_tready = rdy0;
  assign ch1_axis_rq_tready = rdy1;
  assign dma_axis_rq_tvalid = vld_q;
  assign dma_axis_rq_tlast  = last_q;
  assign dma_axis_rq_tdata  = data_q;
  assign dma_axis_rq_tuser  = user_q;
  assign dma_axis_rq_tkeep  = keep_q;
  assign ch0_pkt_cnt        = cnt0_q;
  assign ch1_pkt_cnt        = cnt1_q;

endmodule
